bits_handshake_tx: RTL and testbench
====================================

Name: bits_handshake_tx

Overview:
- Source-side transmitter of a two-phase (toggle) req/ack clock-domain-crossing handshake.
- Captures a data word in the source domain and holds it stable on o_data_a while the destination samples it.
- Signals each new word by toggling o_req_a.
- Waits for the destination's ack toggle, synchronised internally, before accepting the next word.
- Pairs with the destination-side synchroniser/receiver, which retimes o_req_a into its own domain and returns i_ack_b.

Parameters:
- BUS_WIDTH, 8, width of the transferred data word.
- NUM_RETIME, 2, number of flops in the ack synchroniser chain; minimum 2.
- TIMEOUT_CYCLES, 1024, cycles in WAIT_ACK before o_timeout asserts; 0 disables the timeout.
- CNT_WIDTH, 16, width of the timeout counter and of the transfer counter.

Ports:
- i_clk_a  input  1  source-domain clock; the only clock.
- i_rst_n_a  input  1  asynchronous active-low reset.
- i_valid_a  input  1  caller presents a word.
- i_data_a  input  BUS_WIDTH  word to send; sampled only on accept.
- o_ready_a  output  1  block can accept a word this cycle.
- o_data_a  output  BUS_WIDTH  registered word, stable for the whole transfer.
- o_req_a  output  1  request toggle, registered, sent to the destination domain.
- i_ack_b  input  1  ack toggle from the destination domain; asynchronous to i_clk_a.
- o_done_a  output  1  one-cycle pulse when a transfer completes.
- o_timeout  output  1  level; ack is overdue.
- o_xfer_cnt  output  CNT_WIDTH  count of completed transfers; wraps.

Behaviour:
- Reset (async assert, release synchronous to i_clk_a) sets:
  - state IDLE
  - o_req_a=0, o_data_a=0, synchroniser flops=0
  - o_done_a=0, o_timeout=0, o_xfer_cnt=0, timeout counter=0
- ack_s is the last flop of a NUM_RETIME-deep chain clocked by i_clk_a and fed by i_ack_b. Only ack_s is used; i_ack_b never feeds logic directly.
- o_ready_a = (state==IDLE) && (ack_s==o_req_a). Combinational from registers only; no combinational path from i_valid_a. Value is 1 after reset.
- Accept: an edge with i_valid_a && o_ready_a does all of the following:
  - o_data_a <= i_data_a
  - o_req_a <= ~o_req_a
  - state <= WAIT_ACK
  - timeout counter <= 0
- In the cycle after accept: o_req_a has the new value, o_data_a is already valid, and o_ready_a=0.
- i_valid_a while o_ready_a=0 is ignored. No capture, and o_data_a is unchanged.
- WAIT_ACK:
  - Each cycle the timeout counter increments and saturates at its maximum.
  - When ack_s==o_req_a: state <= IDLE, o_done_a=1 for exactly one cycle, o_xfer_cnt <= o_xfer_cnt+1 (wraps at 2^CNT_WIDTH), timeout counter <= 0, o_timeout <= 0.
- Timeout: with TIMEOUT_CYCLES>0, o_timeout rises on the edge where the counter reaches TIMEOUT_CYCLES in WAIT_ACK. It stays high until the ack arrives or reset. The block never aborts and never re-toggles.
- Minimum round trip: accept at edge 0, then o_req_a toggles, then receiver latency, then NUM_RETIME ack sync cycles, then IDLE, then o_ready_a high the next cycle. A back-to-back accept is legal in the same cycle o_ready_a returns.
- o_data_a and o_req_a change only on accept. Both come straight from flops, so no glitches cross the domain.
- Reset mid-transfer: o_req_a returns to 0 and state to IDLE. If the destination's ack is still 1, then after the sync delay ack_s != o_req_a and o_ready_a stays 0 until the destination is also reset and ack returns to 0. No transfer is issued meanwhile.
- i_ack_b toggling while IDLE with ack_s already equal to o_req_a is a protocol error. o_ready_a drops while the levels differ; no other state is corrupted.

Test Plan:
- Reset then idle: o_ready_a=1, o_req_a=0, o_data_a=0, o_xfer_cnt=0 for 20 cycles with i_ack_b=0.
- Single transfer, NUM_RETIME=2: accept 8'hA5, bench returns the ack toggle 3 cycles after o_req_a rises.
  - o_data_a=8'hA5 held throughout.
  - o_done_a pulses once, o_xfer_cnt=1.
  - o_ready_a high 2 cycles after the ack edge plus 1.
- Back-to-back: hold i_valid_a with words 1, 2, 3 and an immediate-ack model.
  - o_req_a toggles 0→1→0→1.
  - Each word is captured only on an o_ready_a cycle.
  - o_xfer_cnt=3.
- Valid while busy: change i_data_a to 8'h5A during WAIT_ACK → o_data_a stays 8'hA5 and o_req_a does not toggle.
- Timeout, TIMEOUT_CYCLES=16: withhold ack.
  - o_timeout rises 16 cycles after accept and stays high.
  - Supplying the ack clears o_timeout and pulses o_done_a.
- Reset mid-transfer after the ack toggled to 1:
  - o_ready_a=0 once the synchroniser settles.
  - Forcing i_ack_b=0 restores o_ready_a=1 after NUM_RETIME cycles.

Source files
------------

// File: rtl/bits_handshake_tx.sv
// bits_handshake_tx: source side of a two-phase req/ack toggle handshake that holds a word stable for the destination
module bits_handshake_tx #(
  parameter int BUS_WIDTH      = 8,
  parameter int NUM_RETIME     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 i_clk_a,
  input  logic                 i_rst_n_a,
  input  logic                 i_valid_a,
  input  logic [BUS_WIDTH-1:0] i_data_a,
  output logic                 o_ready_a,
  output logic [BUS_WIDTH-1:0] o_data_a,
  output logic                 o_req_a,
  input  logic                 i_ack_b,
  output logic                 o_done_a,
  output logic                 o_timeout,
  output logic [CNT_WIDTH-1:0] o_xfer_cnt
);
  typedef enum logic {IDLE, WAIT_ACK} state_t;
  localparam logic [CNT_WIDTH-1:0] TO_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  state_t                state_q, state_d;
  logic [NUM_RETIME-1:0] sync_q, sync_d;
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]  xfer_q, xfer_d;
  logic [CNT_WIDTH-1:0]  tcnt_q, tcnt_d, tcnt_inc;
  logic                  ack_s, match, accept, waiting;
  assign ack_s      = sync_q[NUM_RETIME-1];
  assign match      = ack_s == req_q;
  assign waiting    = state_q == WAIT_ACK;
  assign o_ready_a  = state_q == IDLE && match;
  assign accept     = i_valid_a && o_ready_a;
  assign tcnt_inc   = (tcnt_q == '1) ? tcnt_q : tcnt_q + CNT_WIDTH'(1);
  assign o_data_a   = data_q;
  assign o_req_a    = req_q;
  assign o_done_a   = done_q;
  assign o_timeout  = timeout_q;
  assign o_xfer_cnt = xfer_q;
  // next-state: capture on accept, complete when the synchronised ack matches the request level
  always_comb begin
    sync_d    = {sync_q[NUM_RETIME-2:0], i_ack_b};
    data_d    = accept ? i_data_a : data_q;
    req_d     = accept ? ~req_q : req_q;
    done_d    = waiting && match;
    xfer_d    = done_d ? xfer_q + CNT_WIDTH'(1) : xfer_q;
    state_d   = accept ? WAIT_ACK : (done_d ? IDLE : state_q);
    tcnt_d    = (accept || done_d) ? '0 : (waiting ? tcnt_inc : tcnt_q);
    timeout_d = TO_EN && waiting && !match && (timeout_q || tcnt_inc >= TO_LIM);
  end
  // all state in one register bank; outputs are driven straight from these flops
  always_ff @(posedge i_clk_a or negedge i_rst_n_a) begin
    if (!i_rst_n_a) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      xfer_q    <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      data_q    <= data_d;
      req_q     <= req_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      xfer_q    <= xfer_d;
      tcnt_q    <= tcnt_d;
    end
  end
endmodule

// File: tb/tb_bits_handshake_tx.sv
// tb_bits_handshake_tx: vector table, scoreboard and corner-case sequences for bits_handshake_tx
module tb_bits_handshake_tx;
  logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, ack = 1'b0;
  logic [7:0]  din = '0;
  logic        ready, req, done, tmo;
  logic [7:0]  dout;
  logic [15:0] cnt;
  int tests = 0, fails = 0;

  bits_handshake_tx #(.BUS_WIDTH(8), .NUM_RETIME(2), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)) dut (
    .i_clk_a(clk), .i_rst_n_a(rst_n), .i_valid_a(valid), .i_data_a(din),
    .o_ready_a(ready), .o_data_a(dout), .o_req_a(req), .i_ack_b(ack),
    .o_done_a(done), .o_timeout(tmo), .o_xfer_cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ack;
    logic       ready;
    logic       req;
    logic [7:0] dout;
    logic       done;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [7:0] word;
    logic       req;
  } sb_t;

  vec_t tbl[7];
  sb_t  sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; valid = 1'b0; ack = 1'b0; din = '0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    int idx, lat;
    logic [7:0] last;
    logic exp_req, go;
    sb_t e;

    // reset then idle
    do_reset;
    for (int i = 0; i < 20; i++) begin
      chk("idle ready", ready, 1);
      chk("idle req", req, 0);
      chk("idle data", dout, 0);
      chk("idle cnt", cnt, 0);
      chk("idle timeout", tmo, 0);
      tick;
    end

    // single transfer with ack returned 3 cycles after req rises, busy valid ignored
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 16'd0};
    tbl[3] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 16'd0};
    tbl[4] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 16'd0};
    tbl[5] = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 16'd1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 16'd1};
    for (int i = 0; i < 7; i++) begin
      valid = tbl[i].valid; din = tbl[i].data; ack = tbl[i].ack;
      tick;
      chk($sformatf("vec%0d ready", i), ready, tbl[i].ready);
      chk($sformatf("vec%0d req", i), req, tbl[i].req);
      chk($sformatf("vec%0d data", i), dout, tbl[i].dout);
      chk($sformatf("vec%0d done", i), done, tbl[i].done);
      chk($sformatf("vec%0d cnt", i), cnt, tbl[i].cnt);
    end

    // back-to-back words 1,2,3 with an immediate-ack model
    do_reset;
    idx = 0; last = '0; exp_req = 1'b0;
    for (int c = 0; c < 60 && (idx < 3 || sb.size() > 0); c++) begin
      valid = idx < 3;
      din = 8'(idx + 1);
      ack = req;
      go = ready && valid;
      if (go) begin
        exp_req = ~exp_req;
        sb.push_back('{din, exp_req});
        last = din;
        idx++;
      end
      tick;
      chk("b2b held data", dout, last);
      if (done) begin
        if (sb.size() == 0) chk("b2b spurious done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("b2b done word", dout, e.word);
          chk("b2b done req", req, e.req);
        end
      end
    end
    valid = 1'b0;
    chk("b2b words sent", idx, 3);
    chk("b2b pending", sb.size(), 0);
    chk("b2b final req", req, 1);
    chk("b2b cnt", cnt, 3);

    // timeout: withhold ack, then supply it
    do_reset;
    valid = 1'b1; din = 8'h3C;
    tick;
    valid = 1'b0; din = 8'h5A;
    chk("to req", req, 1);
    for (int k = 1; k <= 20; k++) begin
      tick;
      chk($sformatf("to level k=%0d", k), tmo, k >= 16);
    end
    chk("to data held", dout, 8'h3C);
    ack = 1'b1;
    lat = 0;
    for (int n = 0; n < 10 && !done; n++) begin
      tick;
      lat++;
      if (!done) chk("to held before ack", tmo, 1);
    end
    chk("to done", done, 1);
    chk("to ack latency", lat, 3);
    chk("to cleared", tmo, 0);
    tick;
    chk("to done pulse end", done, 0);
    chk("to cnt", cnt, 1);

    // reset mid-transfer after the ack rose
    do_reset;
    valid = 1'b1; din = 8'h77;
    tick;
    valid = 1'b0;
    chk("mid req", req, 1);
    ack = 1'b1;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst req", req, 0);
    chk("mid rst data", dout, 0);
    chk("mid rst ready", ready, 1);
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    chk("mid settled ready", ready, 0);
    valid = 1'b1; din = 8'h11;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("mid blocked ready", ready, 0);
      chk("mid blocked req", req, 0);
    end
    chk("mid blocked data", dout, 0);
    valid = 1'b0;
    ack = 1'b0;
    tick;
    chk("mid recover 1", ready, 0);
    tick;
    chk("mid recover 2", ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
